prng64_collector: RTL and testbench
===================================

# prng64_collector

Downstream stage of the two 32-bit PCG generators (`pcg1`, `pcg2`) in the PRNG64 datapath. Each enabled cycle it samples both generator outputs, packs them into one 64-bit word and pushes it into a small first-word-fall-through FIFO. Consumers draw words through a valid/ready handshake. The block discards a programmable number of warm-up samples after reset and counts the words it drops while the FIFO is full.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, minimum 2.
- `WARMUP`, 4: enabled cycles discarded after reset; 0 means no discard.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: sample strobe; the generators are sampled only on cycles where `en`=1.
- `rand_hi_in`  in  32: `random_out` of `pcg1`.
- `rand_lo_in`  in  32: `random_out` of `pcg2`.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `out_valid`  out  1: FIFO non-empty.
- `out_data`  out  64: head word; 64'h0 whenever `out_valid`=0.
- `fifo_level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `drop_count`  out  16: saturating count of samples lost to a full FIFO.

## Operation
- State machine with two states.
  - `S_WARM`: entered on reset. Each `en`=1 cycle increments `warm_cnt`; samples are discarded. Move to `S_RUN` on the edge where `warm_cnt` reaches `WARMUP`-1 with `en`=1. If `WARMUP`=0, reset goes directly to `S_RUN`.
  - `S_RUN`: terminal until the next reset.
- Sample word is {`rand_hi_in`, `rand_lo_in`]: hi occupies bits [63:32], lo occupies bits [31:0].
- Push request: `push_req` = (state==`S_RUN`) & `en`.
- Pop: `pop` = `out_valid` & `out_ready`.
- Push is accepted when `push_req` & (!full | `pop`).
  - Full with a simultaneous pop: push is accepted, level is unchanged, no drop.
- Drop: `push_req` & full & !`pop`. `drop_count` increments and saturates at 16'hFFFF.
- Level update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from `fifo_level`.
- Empty FIFO with simultaneous push and pop: there is no bypass. The pop does not occur because `out_valid`=0; the word appears on the next cycle.
- Reset mid-operation:
  - FIFO contents become unreachable; pointers and level clear.
  - `drop_count` clears.
  - State returns to `S_WARM` and the warm-up restarts.

## Timing
- Reset values: `out_valid`=0, `out_data`=64'h0, `fifo_level`=0, `drop_count`=0, state `S_WARM`, `warm_cnt`=0.
- Latency: a sample taken at edge N gives `out_valid`=1 with that word on `out_data` in the cycle after N (one cycle, registered storage).
- Throughput: one word per cycle in and out sustained; with `out_ready` held high the level never exceeds 1.
- `out_valid`/`out_data` change only after a clock edge, except that `out_data` follows the head pointer combinationally from registered state.
- A consumer may deassert `out_ready` at any time. Once `out_valid`=1, the word is held until it is popped or reset is asserted.

## Structure
- Package `prng64_pkg`:
  - `WORD_W`=32, `OUT_W`=64, `DROP_W`=16.
  - enum `collector_state_t` {`S_WARM`, `S_RUN`}.
- Sub-module `prng_fifo`:
  - Parameterised by `DEPTH` and width.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Async active-high reset on pointers and level only; storage is not reset.
- Top level holds the FSM, warm-up counter, drop counter and output gating.

## Test plan
- Reset, `WARMUP`=4, `en`=1, hi=32'hA5A5_0000+n, lo=n -> first 4 samples discarded. The first `out_data` is 64'hA5A5_0004_0000_0004, visible the cycle after the 5th enabled edge.
- `out_ready`=0 for 20 enabled run cycles with `DEPTH`=8 -> `fifo_level`=8 and `drop_count`=12. The 8 words are then read in order.
- FIFO full, `en`=1 and `out_ready`=1 simultaneously -> level stays 8, `drop_count` unchanged, head advances by one word.
- Force 70000 drops -> `drop_count`=16'hFFFF and it stays there.
- `en` toggling 1,0,1,0 during warm-up with `WARMUP`=2 -> `S_RUN` is entered only after the 2nd enabled cycle. `en`=0 cycles push nothing.
- Assert `rst` asynchronously mid-stream with level=5 -> `out_valid`=0, `out_data`=0, level=0 and `drop_count`=0 immediately. After release, warm-up repeats fully.

Source files
------------

// File: rtl/prng64_pkg.sv
// rtl/prng64_pkg.sv - shared widths and state encoding for the PRNG64 collector
package prng64_pkg;
    localparam int WORD_W = 32;
    localparam int OUT_W  = 64;
    localparam int DROP_W = 16;

    typedef enum logic [0:0] {
        S_WARM = 1'b0,
        S_RUN  = 1'b1
    } collector_state_t;
endpackage

// File: rtl/prng_fifo.sv
// rtl/prng_fifo.sv - first-word-fall-through FIFO with occupancy-derived full/empty
module prng_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Caller guarantees push only when not full (or popping) and pop only when non-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
endmodule

// File: rtl/prng64_collector.sv
// rtl/prng64_collector.sv - packs pcg1/pcg2 samples into 64-bit words behind a warm-up gate and FIFO
module prng64_collector
    import prng64_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WORD_W-1:0]        rand_hi_in,
    input  logic [WORD_W-1:0]        rand_lo_in,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam collector_state_t RESET_STATE = (WARMUP == 0) ? S_RUN : S_WARM;

    collector_state_t state;
    logic [WCW-1:0]   warm_cnt;
    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic             full;
    logic             empty;
    logic [OUT_W-1:0] head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET_STATE;
            warm_cnt <= '0;
        end else begin
            case (state)
                S_WARM: begin
                    if (en) begin
                        if (warm_cnt == WARM_LAST) state <= S_RUN;
                        else                       warm_cnt <= warm_cnt + WCW'(1);
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign push_req = (state == S_RUN) && en;
    assign pop      = out_valid && out_ready;
    // A full FIFO still takes a sample when the head leaves on the same edge.
    assign push_ok  = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (push_req && full && !pop && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

    prng_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({rand_hi_in, rand_lo_in}),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_data  = out_valid ? head : '0;
endmodule

// File: tb/tb_prng64_collector.sv
// tb/tb_prng64_collector.sv - scoreboard bench for prng64_collector
module tb_prng64_collector;
    localparam int DEPTH  = 8;
    localparam int WARMUP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] rand_hi_in;
    logic [31:0] rand_lo_in;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  fifo_level;
    logic [15:0] drop_count;

    prng64_collector #(.DEPTH(DEPTH), .WARMUP(WARMUP)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rand_hi_in (rand_hi_in),
        .rand_lo_in (rand_lo_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    bit          m_run;
    int          m_warm;
    logic [15:0] m_drop;
    int unsigned n = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_run  = (WARMUP == 0);
        m_warm = 0;
        m_drop = 16'h0;
    endtask

    task automatic check_all();
        check("out_valid", {63'h0, out_valid}, {63'h0, sb_q.size() != 0});
        check("out_data", out_data, (sb_q.size() != 0) ? sb_q[0] : 64'h0);
        check("fifo_level", {60'h0, fifo_level}, 64'(sb_q.size()));
        check("drop_count", {48'h0, drop_count}, {48'h0, m_drop});
    endtask

    // Drive one cycle, advance the scoreboard for that edge, then compare on the falling edge.
    task automatic step(input logic e, input logic r);
        logic [63:0] word;
        bit          do_pop;
        bit          push_req;
        bit          full;
        en         = e;
        out_ready  = r;
        rand_hi_in = 32'hA5A5_0000 + n;
        rand_lo_in = n;
        word       = {rand_hi_in, rand_lo_in};
        do_pop     = (sb_q.size() != 0) && r;
        push_req   = m_run && e;
        full       = (sb_q.size() == DEPTH);
        if (push_req && full && !do_pop && m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
        if (do_pop) void'(sb_q.pop_front());
        if (push_req && (!full || do_pop)) sb_q.push_back(word);
        if (!m_run && e) begin
            if (m_warm == WARMUP - 1) m_run = 1'b1;
            else                      m_warm++;
        end
        @(posedge clk);
        if (e) n++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; out_ready = 1'b0; rand_hi_in = '0; rand_lo_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", {63'h0, out_valid}, 64'h0);
        check("rst_data", out_data, 64'h0);
        check("rst_level", {60'h0, fifo_level}, 64'h0);
        check("rst_drops", {48'h0, drop_count}, 64'h0);

        // Warm-up discards samples 0..3; sample 4 is the first word out.
        repeat (4) step(1'b1, 1'b0);
        check("warm_empty", {63'h0, out_valid}, 64'h0);
        step(1'b1, 1'b0);
        check("first_word", out_data, 64'hA5A5_0004_0000_0004);

        repeat (19) step(1'b1, 1'b0);
        check("fill_level", {60'h0, fifo_level}, 64'd8);
        check("fill_drops", {48'h0, drop_count}, 64'd12);

        step(1'b1, 1'b1);
        check("full_pop_level", {60'h0, fifo_level}, 64'd8);
        check("full_pop_drops", {48'h0, drop_count}, 64'd12);
        check("full_pop_head", out_data, 64'hA5A5_0005_0000_0005);

        repeat (8) step(1'b0, 1'b1);
        check("drain_level", {60'h0, fifo_level}, 64'd0);

        // Streaming with ready held high keeps occupancy at one.
        repeat (6) begin
            step(1'b1, 1'b1);
            check("stream_level", {60'h0, fifo_level}, 64'd1);
        end
        repeat (2) step(1'b0, 1'b1);

        repeat (5) step(1'b1, 1'b0);
        check("pre_rst_level", {60'h0, fifo_level}, 64'd5);

        #2 rst = 1'b1;
        en = 1'b0;
        #1;
        model_reset();
        check("async_valid", {63'h0, out_valid}, 64'h0);
        check("async_data", out_data, 64'h0);
        check("async_level", {60'h0, fifo_level}, 64'h0);
        check("async_drops", {48'h0, drop_count}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // en toggling during warm-up: only enabled cycles advance the counter.
        for (int i = 0; i < 8; i++) step((i % 2) == 0, 1'b0);
        check("toggle_still_empty", {63'h0, out_valid}, 64'h0);
        step(1'b0, 1'b0);
        check("toggle_idle_empty", {63'h0, out_valid}, 64'h0);
        step(1'b1, 1'b0);
        check("toggle_first_push", {63'h0, out_valid}, 64'h1);

        // Saturation of the drop counter.
        repeat (70010) step(1'b1, 1'b0);
        check("drop_saturated", {48'h0, drop_count}, 64'hFFFF);
        repeat (5) step(1'b1, 1'b0);
        check("drop_held", {48'h0, drop_count}, 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
